// File: rtl/tape_out_tap_framer_if.sv
// Decoded-byte stream between the tape framer (master) and its consumer (slave).
interface tape_out_tap_framer_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/tape_out_tap_framer.sv
// Measures port_FE[3] half-periods, classifies them against tolerance windows and
// frames pilot/sync/bit sequences into TAP bytes with per-block length/XOR status.
module tape_out_tap_framer #(
  parameter int T_CLKS       = 16,
  parameter int TOL_SHIFT    = 3,
  parameter int PILOT_MIN    = 256,
  parameter int SILENCE_CLKS = 113000000,
  parameter int CNT_W        = 27,
  parameter int PILOT_T      = 2168,
  parameter int SYNC1_T      = 667,
  parameter int SYNC2_T      = 735,
  parameter int ZERO_T       = 855,
  parameter int ONE_T        = 1710
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_tape_out,
  input  logic                         i_enable,
  tape_out_tap_framer_if.master        stream,
  output logic                         o_blk_done,
  output logic [15:0]                  o_blk_len,
  output logic                         o_blk_xor_ok,
  output logic                         o_blk_partial,
  output logic                         o_overflow,
  output logic                         o_stream_end
);

  localparam int               PC_W    = $clog2(PILOT_MIN + 1);
  localparam logic [CNT_W-1:0] SILENCE = CNT_W'(SILENCE_CLKS);

  typedef enum logic [2:0] {IDLE, PILOT, SYNC2, BIT_A, BIT_B} state_t;

  state_t           state;
  logic             tape_s1, tape_s2, tape_d;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  pilot_cnt;
  logic [2:0]       bit_ptr;
  logic             bit_cls;
  logic [6:0]       shreg;
  logic [15:0]      len;
  logic [7:0]       xor_acc;
  logic [7:0]       data_q;
  logic             valid_q;

  logic             tape_edge, silence;
  logic             hit_pilot, hit_sync1, hit_sync2, hit_zero, hit_one, same_hit;
  logic             byte_done, close_now;
  logic [7:0]       byte_val;
  logic [15:0]      len_nxt;
  logic [7:0]       xor_nxt;

  // Window test |L - nom| <= nom >> TOL_SHIFT; nom folds to a constant per call site.
  function automatic logic in_win(input logic [CNT_W-1:0] l, input int t_states);
    longint nom, tol, lw;
    nom = longint'(t_states) * longint'(T_CLKS);
    tol = nom >>> TOL_SHIFT;
    lw  = longint'(l);
    return (lw >= nom - tol) && (lw <= nom + tol);
  endfunction

  assign stream.o_data  = data_q;
  assign stream.o_valid = valid_q;

  always_comb begin
    tape_edge = tape_s2 ^ tape_d;
    silence   = !tape_edge && (cnt == SILENCE);
    hit_pilot = in_win(cnt, PILOT_T);
    hit_sync1 = in_win(cnt, SYNC1_T);
    hit_sync2 = in_win(cnt, SYNC2_T);
    hit_zero  = in_win(cnt, ZERO_T);
    hit_one   = in_win(cnt, ONE_T);
    same_hit  = bit_cls ? hit_one : hit_zero;
    byte_val  = {shreg, bit_cls};
    byte_done = i_enable && tape_edge && (state == BIT_B) && same_hit && (bit_ptr == 3'd0);
    close_now = i_enable && ((tape_edge && (state == BIT_A) && !hit_zero && !hit_one) ||
                             (tape_edge && (state == BIT_B) && !same_hit) ||
                             (silence && ((state == BIT_A) || (state == BIT_B))));
    len_nxt   = len;
    xor_nxt   = xor_acc;
    if (byte_done) begin
      len_nxt = (len == 16'hFFFF) ? len : len + 16'd1;
      xor_nxt = xor_acc ^ byte_val;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      tape_s1       <= 1'b0;
      tape_s2       <= 1'b0;
      tape_d        <= 1'b0;
      cnt           <= '0;
      pilot_cnt     <= '0;
      bit_ptr       <= 3'd7;
      bit_cls       <= 1'b0;
      shreg         <= '0;
      len           <= '0;
      xor_acc       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      o_blk_done    <= 1'b0;
      o_blk_len     <= '0;
      o_blk_xor_ok  <= 1'b0;
      o_blk_partial <= 1'b0;
      o_overflow    <= 1'b0;
      o_stream_end  <= 1'b0;
    end else begin
      tape_s1      <= i_tape_out;
      tape_s2      <= tape_s1;
      tape_d       <= tape_s2;
      o_blk_done   <= 1'b0;
      o_stream_end <= 1'b0;

      if (tape_edge) cnt <= CNT_W'(1);
      else if (cnt != '1) cnt <= cnt + 1'b1;

      // A byte arriving while the previous one is still unaccepted is dropped but still counted.
      if (byte_done) begin
        len     <= len_nxt;
        xor_acc <= xor_nxt;
        if (valid_q && !stream.i_ready) begin
          o_overflow <= 1'b1;
        end else begin
          data_q  <= byte_val;
          valid_q <= 1'b1;
        end
      end else if (valid_q && stream.i_ready) begin
        valid_q <= 1'b0;
      end

      if (close_now && ((len_nxt != 16'd0) || (bit_ptr != 3'd7))) begin
        o_blk_done    <= 1'b1;
        o_blk_len     <= len_nxt;
        o_blk_xor_ok  <= (xor_nxt == 8'd0) && (len_nxt != 16'd0);
        o_blk_partial <= (bit_ptr != 3'd7);
      end

      if (!i_enable) begin
        state <= IDLE;
      end else if (tape_edge) begin
        unique case (state)
          IDLE: if (hit_pilot) begin
            state     <= PILOT;
            pilot_cnt <= PC_W'(1);
          end
          PILOT: if (hit_pilot) begin
            if (pilot_cnt != '1) pilot_cnt <= pilot_cnt + 1'b1;
          end else if (hit_sync1 && (pilot_cnt >= PC_W'(PILOT_MIN))) begin
            state <= SYNC2;
          end else begin
            state <= IDLE;
          end
          SYNC2: if (hit_sync2) begin
            state   <= BIT_A;
            bit_ptr <= 3'd7;
            len     <= '0;
            xor_acc <= '0;
          end else begin
            state <= IDLE;
          end
          // Each bit is two equal half-periods; the first picks the class, the second confirms it.
          BIT_A: if (hit_zero) begin
            bit_cls <= 1'b0;
            state   <= BIT_B;
          end else if (hit_one) begin
            bit_cls <= 1'b1;
            state   <= BIT_B;
          end else if (hit_pilot) begin
            state     <= PILOT;
            pilot_cnt <= PC_W'(1);
          end else begin
            state <= IDLE;
          end
          BIT_B: if (same_hit) begin
            shreg   <= byte_val[6:0];
            bit_ptr <= bit_ptr - 3'd1;
            state   <= BIT_A;
          end else begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (silence && (state != IDLE)) begin
        o_stream_end <= 1'b1;
        state        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_tape_out_tap_framer.sv
// Directed bench for tape_out_tap_framer with scaled-down timing so whole blocks fit in a short run.
module tb_tape_out_tap_framer;

  localparam int P   = 216;
  localparam int S1  = 66;
  localparam int S2  = 74;
  localparam int Z   = 86;
  localparam int O   = 172;
  localparam int Z12 = 96;
  localparam int Z14 = 98;
  localparam int NP  = 12;
  localparam int SIL_WAIT = 1100;

  logic        clk = 1'b0;
  logic        reset;
  logic        tape;
  logic        enable;
  logic        blk_done;
  logic [15:0] blk_len;
  logic        blk_xor_ok;
  logic        blk_partial;
  logic        overflow;
  logic        stream_end;

  int          compared = 0;
  int          mismatched = 0;
  int          done_cnt = 0;
  int          end_cnt = 0;
  logic [15:0] last_len = '0;
  logic        last_xor_ok = 1'b0;
  logic        last_partial = 1'b0;
  logic [7:0]  rx_q[$];

  tape_out_tap_framer_if bus();

  tape_out_tap_framer #(
    .T_CLKS(2), .TOL_SHIFT(3), .PILOT_MIN(8), .SILENCE_CLKS(1000), .CNT_W(12),
    .PILOT_T(108), .SYNC1_T(33), .SYNC2_T(37), .ZERO_T(43), .ONE_T(86)
  ) dut (
    .i_clock(clk),
    .i_reset(reset),
    .i_tape_out(tape),
    .i_enable(enable),
    .stream(bus),
    .o_blk_done(blk_done),
    .o_blk_len(blk_len),
    .o_blk_xor_ok(blk_xor_ok),
    .o_blk_partial(blk_partial),
    .o_overflow(overflow),
    .o_stream_end(stream_end)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled on the falling edge, mid-way between active edges.
  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) rx_q.push_back(bus.o_data);
    if (blk_done) begin
      done_cnt     = done_cnt + 1;
      last_len     = blk_len;
      last_xor_ok  = blk_xor_ok;
      last_partial = blk_partial;
    end
    if (stream_end) end_cnt = end_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkByte(input string tag, input logic [7:0] exp);
    logic [31:0] obs;
    obs = 32'hDEAD_BEEF;
    if (rx_q.size() != 0) obs = {24'd0, rx_q.pop_front()};
    checkOutput(tag, obs, {24'd0, exp});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One half-period: toggle the tape level, then hold it for n clocks.
  task automatic applyStimulus(input int n);
    tape = ~tape;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendLead(input int npilot);
    repeat (npilot) applyStimulus(P);
    applyStimulus(S1);
    applyStimulus(S2);
  endtask

  task automatic sendBits(input logic [7:0] b, input int nbits, input int zlen, input int olen);
    for (int i = 7; i > 7 - nbits; i--) begin
      applyStimulus(b[i] ? olen : zlen);
      applyStimulus(b[i] ? olen : zlen);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd0);
    checkOutput({tag, "_data"}, {24'd0, bus.o_data}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, blk_done}, 32'd0);
    checkOutput({tag, "_len"}, {16'd0, blk_len}, 32'd0);
    checkOutput({tag, "_xor_ok"}, {31'd0, blk_xor_ok}, 32'd0);
    checkOutput({tag, "_partial"}, {31'd0, blk_partial}, 32'd0);
    checkOutput({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    checkOutput({tag, "_stream_end"}, {31'd0, stream_end}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tape = 1'b0;
    enable = 1'b1;
    bus.i_ready = 1'b0;
    waitCycles(3);
    checkQuiet("rst");
    reset = 1'b0;
    bus.i_ready = 1'b1;
    waitCycles(500);

    // Single 0xA5 block closed by silence.
    sendLead(NP);
    sendBits(8'hA5, 8, Z, O);
    tape = ~tape;
    waitCycles(SIL_WAIT);
    checkOutput("a5_count", rx_q.size(), 1);
    checkByte("a5_byte", 8'hA5);
    checkOutput("a5_done", done_cnt, 1);
    checkOutput("a5_len", {16'd0, last_len}, 1);
    checkOutput("a5_xor_ok", {31'd0, last_xor_ok}, 0);
    checkOutput("a5_partial", {31'd0, last_partial}, 0);
    checkOutput("a5_stream_end", end_cnt, 1);

    // Three bytes whose XOR cancels.
    sendLead(NP);
    sendBits(8'hFF, 8, Z, O);
    sendBits(8'h12, 8, Z, O);
    sendBits(8'hED, 8, Z, O);
    tape = ~tape;
    waitCycles(SIL_WAIT);
    checkByte("three_b0", 8'hFF);
    checkByte("three_b1", 8'h12);
    checkByte("three_b2", 8'hED);
    checkOutput("three_done", done_cnt, 2);
    checkOutput("three_len", {16'd0, last_len}, 3);
    checkOutput("three_xor_ok", {31'd0, last_xor_ok}, 1);
    checkOutput("three_partial", {31'd0, last_partial}, 0);
    checkOutput("three_stream_end", end_cnt, 2);

    // +12% zeros accepted, then a +14% zero closes the block mid-byte.
    sendLead(NP);
    sendBits(8'h5A, 8, Z12, O);
    sendBits(8'hA0, 3, Z, O);
    applyStimulus(Z14);
    tape = ~tape;
    waitCycles(SIL_WAIT);
    checkByte("tol_byte", 8'h5A);
    checkOutput("tol_done", done_cnt, 3);
    checkOutput("tol_len", {16'd0, last_len}, 1);
    checkOutput("tol_partial", {31'd0, last_partial}, 1);
    checkOutput("tol_xor_ok", {31'd0, last_xor_ok}, 0);
    checkOutput("tol_stream_end", end_cnt, 2);

    // Too few pilot half-periods before sync: nothing decoded.
    sendLead(NP / 2);
    sendBits(8'hA5, 8, Z, O);
    tape = ~tape;
    waitCycles(SIL_WAIT);
    checkOutput("short_bytes", rx_q.size(), 0);
    checkOutput("short_done", done_cnt, 3);
    checkOutput("short_stream_end", end_cnt, 2);

    // Consumer stalled across two bytes.
    bus.i_ready = 1'b0;
    sendLead(NP);
    sendBits(8'h11, 8, Z, O);
    sendBits(8'h22, 8, Z, O);
    tape = ~tape;
    waitCycles(10);
    checkOutput("ovf_valid", {31'd0, bus.o_valid}, 1);
    checkOutput("ovf_data", {24'd0, bus.o_data}, 32'h11);
    checkOutput("ovf_flag", {31'd0, overflow}, 1);
    waitCycles(SIL_WAIT);
    checkOutput("ovf_done", done_cnt, 4);
    checkOutput("ovf_len", {16'd0, last_len}, 2);
    checkOutput("ovf_xor_ok", {31'd0, last_xor_ok}, 0);
    checkOutput("ovf_stream_end", end_cnt, 3);
    bus.i_ready = 1'b1;
    waitCycles(5);
    checkByte("ovf_held_byte", 8'h11);
    checkOutput("ovf_rx_empty", rx_q.size(), 0);
    checkOutput("ovf_valid_clr", {31'd0, bus.o_valid}, 0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 1);

    // Reset after four bits of a block, then a clean block.
    sendLead(NP);
    sendBits(8'hC3, 4, Z, O);
    @(posedge clk);
    #1 reset = 1'b1;
    waitCycles(1);
    checkQuiet("midrst");
    reset = 1'b0;
    waitCycles(500);
    checkOutput("midrst_no_done", done_cnt, 4);
    sendLead(NP);
    sendBits(8'hC3, 8, Z, O);
    tape = ~tape;
    waitCycles(SIL_WAIT);
    checkByte("post_byte", 8'hC3);
    checkOutput("post_done", done_cnt, 5);
    checkOutput("post_len", {16'd0, last_len}, 1);
    checkOutput("post_partial", {31'd0, last_partial}, 0);
    checkOutput("post_stream_end", end_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
